pwm_duty_measure: RTL and testbench



---
 rtl/pwm_duty_measure.sv | 196 +++++++++++++++++++
 tb/tb_pwm_duty_measure.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_measure.sv
// pwm_duty_measure: measures high time and period of one PWM line and converts the duty to 0..255.
// Build option PWM_DUTY_MEASURE_GLITCH_FILTER_EN inserts a 3-sample stability filter (+2 clocks latency).
//
// state        | meaning
// -------------+--------------------------------------------------------------
// ST_WAIT_RISE | after reset/timeout: wait for first rise, partial period dropped
// ST_HIGH      | line high, waiting for the fall that ends the high time
// ST_LOW       | line low, waiting for the rise that closes the period
// ST_DIVIDE    | restoring divide high*255 / period, one quotient bit per clock
// ST_PUBLISH   | drive results, pulse o_valid, clear o_timeout
module pwm_duty_measure #(
   parameter int unsigned parm_FCLK                    = 40_000_000,
   parameter int unsigned parm_pwm_period_milliseconds = 10,
   parameter int unsigned parm_timeout_periods         = 2,
   parameter int unsigned parm_min_period_cycles       = 16
) (
   input  logic        i_clk,
   input  logic        i_srst,
   input  logic        ei_pwm,
   output logic [7:0]  o_duty_value,
   output logic [31:0] o_high_cycles,
   output logic [31:0] o_period_cycles,
   output logic        o_valid,
   output logic        o_timeout,
   output logic [7:0]  o_discard_count
);

   localparam int unsigned c_nominal_cycles = parm_FCLK / 1000 * parm_pwm_period_milliseconds;
   localparam int unsigned c_timeout_cycles = c_nominal_cycles * parm_timeout_periods;

   typedef enum logic [2:0] {
      ST_WAIT_RISE,
      ST_HIGH,
      ST_LOW,
      ST_DIVIDE,
      ST_PUBLISH
   } state_t;

   state_t      st, st_nxt;
   logic [1:0]  s_sync;
   logic        s_line, s_prev, s_rise, s_fall, s_tmo;
   logic [31:0] s_cnt, s_high, s_period, s_div_high;
   logic [39:0] s_rem, s_div;
   logic [7:0]  s_quot;
   logic [2:0]  s_bit_cnt;
   logic        s_fall_seen;
   logic        c_load, c_discard, c_publish, c_timeout;

   always_ff @(posedge i_clk) begin
      if (i_srst) s_sync <= 2'b00;
      else        s_sync <= {s_sync[0], ei_pwm};
   end

`ifdef PWM_DUTY_MEASURE_GLITCH_FILTER_EN
   logic [1:0] s_hist;
   logic       s_filt_q;

   // Level only moves once the synchronized line has held the same value for 3 clocks.
   always_comb begin
      s_line = s_filt_q;
      if (s_sync[1] == s_hist[0] && s_hist[0] == s_hist[1]) s_line = s_sync[1];
   end

   always_ff @(posedge i_clk) begin
      if (i_srst) begin
         s_hist   <= 2'b00;
         s_filt_q <= 1'b0;
      end else begin
         s_hist   <= {s_hist[0], s_sync[1]};
         s_filt_q <= s_line;
      end
   end
`else
   assign s_line = s_sync[1];
`endif

   assign s_rise = s_line & ~s_prev;
   assign s_fall = ~s_line & s_prev;
   // An edge in the same cycle always beats the timeout.
   assign s_tmo  = (s_cnt == c_timeout_cycles) && !s_rise && !s_fall;

   always_comb begin
      st_nxt    = st;
      c_load    = 1'b0;
      c_discard = 1'b0;
      c_publish = 1'b0;
      c_timeout = 1'b0;
      case (st)
         ST_WAIT_RISE: begin
            if (s_rise)     st_nxt = ST_HIGH;
            else if (s_tmo) c_timeout = 1'b1;
         end
         ST_HIGH: begin
            if (s_fall) st_nxt = ST_LOW;
            else if (s_tmo) begin
               c_timeout = 1'b1;
               st_nxt    = ST_WAIT_RISE;
            end
         end
         ST_LOW: begin
            if (s_rise) begin
               if (s_cnt >= parm_min_period_cycles) begin
                  c_load = 1'b1;
                  st_nxt = ST_DIVIDE;
               end else begin
                  c_discard = 1'b1;
                  st_nxt    = ST_HIGH;
               end
            end else if (s_tmo) begin
               c_timeout = 1'b1;
               st_nxt    = ST_WAIT_RISE;
            end
         end
         ST_DIVIDE: begin
            if (s_bit_cnt == 3'd0) st_nxt = ST_PUBLISH;
         end
         ST_PUBLISH: begin
            c_publish = 1'b1;
            st_nxt    = (s_fall_seen || s_fall) ? ST_LOW : ST_HIGH;
         end
         default: st_nxt = ST_WAIT_RISE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_srst) begin
         st              <= ST_WAIT_RISE;
         s_prev          <= 1'b0;
         s_cnt           <= 32'd0;
         s_high          <= 32'd0;
         s_period        <= 32'd0;
         s_div_high      <= 32'd0;
         s_rem           <= 40'd0;
         s_div           <= 40'd0;
         s_quot          <= 8'd0;
         s_bit_cnt       <= 3'd0;
         s_fall_seen     <= 1'b0;
         o_duty_value    <= 8'd0;
         o_high_cycles   <= 32'd0;
         o_period_cycles <= 32'd0;
         o_valid         <= 1'b0;
         o_timeout       <= 1'b0;
         o_discard_count <= 8'd0;
      end else begin
         st      <= st_nxt;
         s_prev  <= s_line;
         o_valid <= c_publish | c_timeout;

         if (s_rise)               s_cnt <= 32'd1;
         else if (s_cnt != '1)     s_cnt <= s_cnt + 32'd1;

         // Falls landing mid-divide are kept; s_div_high holds the value being divided.
         if (s_fall) begin
            s_high      <= s_cnt;
            s_fall_seen <= 1'b1;
         end

         if (c_load || c_discard) s_period <= s_cnt;

         if (c_load) begin
            s_div_high  <= s_high;
            s_rem       <= {s_high, 8'h00} - {8'h00, s_high};
            s_div       <= {1'b0, s_cnt, 7'b0};
            s_quot      <= 8'd0;
            s_bit_cnt   <= 3'd7;
            s_fall_seen <= 1'b0;
         end

         if (st == ST_DIVIDE) begin
            if (s_rem >= s_div) begin
               s_rem  <= s_rem - s_div;
               s_quot <= {s_quot[6:0], 1'b1};
            end else begin
               s_quot <= {s_quot[6:0], 1'b0};
            end
            s_div     <= s_div >> 1;
            s_bit_cnt <= s_bit_cnt - 3'd1;
         end

         if (c_discard && o_discard_count != 8'hFF) o_discard_count <= o_discard_count + 8'd1;

         if (c_publish) begin
            o_duty_value    <= s_quot;
            o_high_cycles   <= s_div_high;
            o_period_cycles <= s_period;
            o_timeout       <= 1'b0;
         end else if (c_timeout) begin
            o_duty_value    <= s_line ? 8'hFF : 8'h00;
            o_high_cycles   <= 32'd0;
            o_period_cycles <= 32'd0;
            o_timeout       <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pwm_duty_measure.sv
// tb_pwm_duty_measure: drives PWM segments, predicts results from high/period arithmetic,
// and checks them in a decoupled monitor as o_valid pulses arrive.
module tb_pwm_duty_measure;

   localparam int C_TMO = 2000;
`ifdef PWM_DUTY_MEASURE_GLITCH_FILTER_EN
   localparam int IN_LAT = 5;
   localparam int HI_MAX = 997;
   localparam int LO_MIN = 3;
`else
   localparam int IN_LAT = 3;
   localparam int HI_MAX = 999;
   localparam int LO_MIN = 1;
`endif
   localparam int LAT = IN_LAT + 9;

   typedef struct {
      int          cyc;
      logic [7:0]  duty;
      logic [31:0] high;
      logic [31:0] period;
      logic        to;
   } exp_t;

   logic        clk = 1'b0;
   logic        i_srst = 1'b1;
   logic        pwm = 1'b0;
   logic [7:0]  o_duty_value;
   logic [31:0] o_high_cycles;
   logic [31:0] o_period_cycles;
   logic        o_valid;
   logic        o_timeout;
   logic [7:0]  o_discard_count;

   int   cyc = 0;
   int   n_checks = 0;
   int   n_errors = 0;
   exp_t q[$];
   bit   armed = 0;
   int   last_rise = 0;
   int   last_fall = 0;
   int   disc_model = 0;
   logic to_level = 1'b0;

   pwm_duty_measure #(
      .parm_FCLK                    (100_000),
      .parm_pwm_period_milliseconds (10),
      .parm_timeout_periods         (2),
      .parm_min_period_cycles       (16)
   ) dut (
      .i_clk           (clk),
      .i_srst          (i_srst),
      .ei_pwm          (pwm),
      .o_duty_value    (o_duty_value),
      .o_high_cycles   (o_high_cycles),
      .o_period_cycles (o_period_cycles),
      .o_valid         (o_valid),
      .o_timeout       (o_timeout),
      .o_discard_count (o_discard_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_duty"},    o_duty_value,    0);
      chk({tag, "_high"},    o_high_cycles,   0);
      chk({tag, "_period"},  o_period_cycles, 0);
      chk({tag, "_valid"},   o_valid,         0);
      chk({tag, "_timeout"}, o_timeout,       0);
      chk({tag, "_discard"}, o_discard_count, 0);
   endtask

   // Reference model: a period closes on every rise after the first; duty = floor(high*255/period).
   task automatic model_rise(input int n);
      longint h, p;
      if (armed) begin
         h = last_fall - last_rise;
         p = n - last_rise;
         if (p < 16) begin
            if (disc_model < 255) disc_model++;
         end else begin
            q.push_back('{cyc: n + LAT, duty: 8'((h * 255) / p),
                          high: 32'(h), period: 32'(p), to: 1'b0});
         end
      end
      armed     = 1;
      last_rise = n;
   endtask

   task automatic model_fall(input int n);
      last_fall = n;
   endtask

   task automatic model_reset();
      q.delete();
      armed      = 0;
      disc_model = 0;
   endtask

   // One PWM segment: rise, h clocks high, l clocks low; optional reset pulse at offset rst_at.
   task automatic seg(input int h, input int l, input int rst_at = -10);
      int n;
      n   = cyc;
      pwm = 1'b1;
      model_rise(n);
      if (h + l > C_TMO) begin
         q.push_back('{cyc: n + C_TMO + IN_LAT, duty: (h > C_TMO) ? 8'hFF : 8'h00,
                       high: 32'd0, period: 32'd0, to: 1'b1});
         armed = 0;
      end
      for (int i = 0; i < h + l; i++) begin
         if (i == h) begin
            pwm = 1'b0;
            model_fall(cyc);
         end
         if (rst_at >= 0 && i == rst_at) i_srst = 1'b1;
         if (rst_at >= 0 && i == rst_at + 1) begin
            chk_zero("mid_reset");
            i_srst = 1'b0;
            model_reset();
         end
         @(negedge clk);
      end
   endtask

   // 250/750 period with a 2-clock low glitch 100 clocks into the high phase.
   task automatic glitch_seg();
      pwm = 1'b1;
      model_rise(cyc);
      repeat (100) @(negedge clk);
      pwm = 1'b0;
`ifndef PWM_DUTY_MEASURE_GLITCH_FILTER_EN
      model_fall(cyc);
`endif
      repeat (2) @(negedge clk);
      pwm = 1'b1;
`ifndef PWM_DUTY_MEASURE_GLITCH_FILTER_EN
      model_rise(cyc);
`endif
      repeat (148) @(negedge clk);
      pwm = 1'b0;
      model_fall(cyc);
      repeat (750) @(negedge clk);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (i_srst) begin
            to_level = 1'b0;
         end else if (o_valid) begin
            if (q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_valid: got o_valid=1 expected no pending result (cycle %0d)", cyc);
            end else begin
               e = q.pop_front();
               chk("valid_cycle", cyc,             e.cyc);
               chk("duty",        o_duty_value,    e.duty);
               chk("high",        o_high_cycles,   e.high);
               chk("period",      o_period_cycles, e.period);
               chk("timeout",     o_timeout,       e.to);
               to_level = e.to;
            end
         end else begin
            chk("timeout_level", o_timeout, to_level);
         end
      end
   end

   initial begin : stimulus
      repeat (3) @(negedge clk);
      chk_zero("reset");
      i_srst = 1'b0;
      model_reset();
      repeat (10) @(negedge clk);

      repeat (3) seg(250, 750);
      repeat (2) seg(800, 200);
      repeat (2) seg(HI_MAX, LO_MIN);
      seg(8, 500);
      seg(9, 500);
      seg(250, 750);

      seg(2100, 100);
      seg(250, 750);
      seg(100, 2100);
      seg(250, 750);
      seg(250, 750);

      i_srst = 1'b1;
      @(negedge clk);
      i_srst = 1'b0;
      model_reset();
      repeat (10) @(negedge clk);
      repeat (5) seg(4, 4);
      seg(250, 750);
      chk("discard_count", o_discard_count, disc_model);
      seg(250, 750);

      seg(250, 750);
      seg(4, 300, 6);
      repeat (3) seg(250, 750);

      glitch_seg();
      repeat (2) seg(250, 750);

      for (int k = 0; k < 24; k++) begin
         if ($urandom_range(0, 3) == 0) seg($urandom_range(3, 6), $urandom_range(7, 9));
         else                           seg($urandom_range(5, 900), $urandom_range(5, 900));
      end
      seg(250, 750);

      repeat (40) @(negedge clk);
      chk("pending_results", q.size(), 0);
      chk("discard_final", o_discard_count, disc_model);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
